// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
// Handshake: req/addr/web/wdata held stable until a single-cycle ready pulse.
interface mem_stage_if;
    logic        dm_req_o;
    logic [31:0] dm_addr_o;
    logic [3:0]  dm_web_o;
    logic [31:0] dm_wdata_o;
    logic        dm_ready_i;
    logic [31:0] dm_rdata_i;

    modport master (
        output dm_req_o, dm_addr_o, dm_web_o, dm_wdata_o,
        input  dm_ready_i, dm_rdata_i
    );

    modport slave (
        input  dm_req_o, dm_addr_o, dm_web_o, dm_wdata_o,
        output dm_ready_i, dm_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: registers EX results, runs the data-memory access, aligns loads, combines multiply partials.
// Latency 1 cycle for ALU/MUL ops, 1+N+1 for loads/stores; stalls upstream while an access is outstanding.
module mem_stage (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid_i,
    input  logic [31:0]      ex_insn_i,
    input  logic [31:0]      ex_alu_result_i,
    input  logic [31:0]      ex_mem_wdata_i,
    input  logic [3:0]       ex_mem_web_i,
    input  logic [3:0][31:0] ex_mul_part_i,
    input  logic [1:0]       ex_rs1_rs2_sign_i,
    input  logic             flush_i,
    mem_stage_if.master      dm,
    output logic             mem_stall_o,
    output logic             mem_wb_valid_o,
    output logic             mem_wb_en_o,
    output logic [4:0]       mem_rd_o,
    output logic [31:0]      mem_wb_data_o
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [31:0]      insn;
        logic [31:0]      alu;
        logic [31:0]      wdata;
        logic [3:0]       web;
        logic [3:0][31:0] part;
        logic [1:0]       sign;
    } m_t;

    m_t          m_q, m_d;
    state_t      state_q, state_d;
    logic [31:0] ld_q, ld_d;
    logic        cap_mem_op;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_mul;
    logic [63:0] prod, prod_neg;
    logic [31:0] mul_res, shifted;
    logic [15:0] half;

    assign opcode  = m_q.insn[6:0];
    assign funct3  = m_q.insn[14:12];
    assign is_load = (opcode == OP_LOAD);
    assign is_mul  = (opcode == OP_R) && (m_q.insn[31:25] == 7'b0000001) && !funct3[2];

    // Squashed or empty EX slots become an all-zero bubble so no stale fields leak out.
    always_comb begin
        m_d = '0;
        if (ex_valid_i && !flush_i) begin
            m_d.valid = 1'b1;
            m_d.insn  = ex_insn_i;
            m_d.alu   = ex_alu_result_i;
            m_d.wdata = ex_mem_wdata_i;
            m_d.web   = ex_mem_web_i;
            m_d.part  = ex_mul_part_i;
            m_d.sign  = ex_rs1_rs2_sign_i;
        end
    end

    assign cap_mem_op = m_d.valid && (m_d.insn[6:0] == OP_LOAD || m_d.insn[6:0] == OP_STORE);

    always_ff @(posedge clk) begin
        if (rst)
            m_q <= '0;
        else if (!mem_stall_o)
            m_q <= m_d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (dm.dm_ready_i) state_d = DONE;
            default: state_d = cap_mem_op ? ACC : IDLE;
        endcase
    end

    // Load alignment: byte lane from addr[1:0]; halfword is low for addr 00, high otherwise.
    always_comb begin
        shifted = dm.dm_rdata_i >> {m_q.alu[1:0], 3'b000};
        half    = (m_q.alu[1:0] == 2'b00) ? dm.dm_rdata_i[15:0] : dm.dm_rdata_i[31:16];
        case (funct3)
            3'b000:  ld_d = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_d = {24'b0, shifted[7:0]};
            3'b001:  ld_d = {{16{half[15]}}, half};
            3'b101:  ld_d = {16'b0, half};
            default: ld_d = dm.dm_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            ld_q <= '0;
        else if (state_q == ACC && dm.dm_ready_i && is_load)
            ld_q <= ld_d;
    end

    always_comb begin
        prod = {32'b0, m_q.part[0]}
             + {16'b0, m_q.part[1], 16'b0}
             + {16'b0, m_q.part[2], 16'b0}
             + {m_q.part[3], 32'b0};
        prod_neg = -prod;
        case (funct3[1:0])
            2'b00:   mul_res = prod[31:0];
            2'b01:   mul_res = (m_q.sign[1] ^ m_q.sign[0]) ? prod_neg[63:32] : prod[63:32];
            2'b10:   mul_res = m_q.sign[1] ? prod_neg[63:32] : prod[63:32];
            default: mul_res = prod[63:32];
        endcase
    end

    always_comb begin
        mem_stall_o    = (state_q == ACC);
        dm.dm_req_o    = 1'b0;
        dm.dm_addr_o   = '0;
        dm.dm_web_o    = 4'b1111;
        dm.dm_wdata_o  = '0;
        if (state_q == ACC) begin
            dm.dm_req_o   = 1'b1;
            dm.dm_addr_o  = m_q.alu;
            dm.dm_web_o   = m_q.web;
            dm.dm_wdata_o = m_q.wdata;
        end
        mem_wb_valid_o = m_q.valid && (state_q != ACC);
        mem_rd_o       = m_q.insn[11:7];
        mem_wb_en_o    = mem_wb_valid_o && (mem_rd_o != 5'd0) &&
                         (opcode inside {OP_R, OP_I, OP_LOAD, OP_AUIPC, OP_LUI, OP_JAL, OP_JALR, OP_CSR});
        if (is_load)
            mem_wb_data_o = ld_q;
        else if (is_mul)
            mem_wb_data_o = mul_res;
        else
            mem_wb_data_o = m_q.alu;
    end

    logic unused_bits;
    assign unused_bits = ^{m_q.insn[24:15], prod_neg[31:0]};
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Ports, clock and reset first; one line each: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid_i  in  1  EX holds a valid instruction.
- ex_insn_i  in  32  instruction word.
- ex_alu_result_i  in  32  ALU result / effective address.
- ex_mem_wdata_i  in  32  lane-aligned store data.
- ex_mem_web_i  in  4  byte write enables, active low.
- ex_mul_part_i  in  4x32  16x16 partial products [0]=LL, [1]=HL, [2]=LH, [3]=HH.
- ex_rs1_rs2_sign_i  in  2  [1]=rs1[31], [0]=rs2[31].
- flush_i  in  1  the instruction currently in EX is squashed.
- dm_req_o  out  1  data-memory request.
- dm_addr_o  out  32  byte address.
- dm_web_o  out  4  byte write enables, active low; 4'b1111 = read.
- dm_wdata_o  out  32  store data.
- dm_ready_i  in  1  one-cycle pulse: access complete.
- dm_rdata_i  in  32  read data, valid with dm_ready_i.
- mem_stall_o  out  1  upstream must hold EX contents.
- mem_wb_valid_o  out  1  writeback fields valid this cycle.
- mem_wb_en_o  out  1  register-file write enable.
- mem_rd_o  out  5  destination register, insn[11:7].
- mem_wb_data_o  out  32  writeback data.

Function
REQ-002 The pipeline register M captures all ex_* inputs on each rising edge where mem_stall_o=0; when flush_i=1 or ex_valid_i=0, it captures a bubble (valid=0).
REQ-003 mem_op = M.valid & (opcode 0000011 load or 0100011 store).
REQ-004 FSM states: IDLE, ACC, DONE.
- IDLE -> ACC on a capture of a mem_op; otherwise it stays in IDLE.
- ACC -> DONE on dm_ready_i=1; otherwise it stays in ACC.
- DONE behaves as IDLE: next state is ACC on a mem_op capture, else IDLE.
REQ-005 In ACC: dm_req_o=1, dm_addr_o=M.alu_result, dm_web_o=M.web, dm_wdata_o=M.wdata, all held stable until dm_ready_i. Outside ACC, dm_req_o=0, dm_web_o=4'b1111, and dm_addr_o/dm_wdata_o=0.
REQ-006 mem_stall_o=1 in ACC only, including the cycle in which dm_ready_i arrives. A mem_op therefore occupies 1 + N + 1 cycles, where N is the number of wait cycles.
REQ-007 On dm_ready_i for a load, the aligned and extended read data is registered into LD.
- LW: full word.
- LB/LBU: byte selected by addr[1:0], sign- or zero-extended.
- LH/LHU: addr[1:0]=00 selects [15:0]; any other value selects [31:16]; sign- or zero-extended.
REQ-008 Multiply combine, for R-type with funct7=0000001. P = part0 + (part1<<16) + (part2<<16) + (part3<<32), computed in 64 bits modulo 2^64.
- MUL: P[31:0].
- MULHU: P[63:32].
- MULH: (sign1^sign0 ? -P : P)[63:32].
- MULHSU: (sign1 ? -P : P)[63:32].
REQ-009 mem_wb_data_o selection:
- Load: LD.
- MUL family: the REQ-008 result.
- Otherwise: M.alu_result.
REQ-010 mem_wb_valid_o = M.valid & (state != ACC). For a mem_op it is asserted only in DONE.
REQ-011 mem_wb_en_o = mem_wb_valid_o & rd!=0 & opcode in {R, I, L, AUIPC, LUI, JAL, JALR, CSR}. Stores and branches never write.
REQ-012 If dm_ready_i arrives outside ACC, it is ignored. flush_i does not affect an instruction already in M.

Reset
REQ-013 When rst=1 at a clock edge:
- M.valid=0, state=IDLE, LD=0.
- All outputs are 0, except dm_web_o=4'b1111.
REQ-014 Reset during ACC abandons the access: dm_req_o=0 on the next cycle, and any later dm_ready_i is ignored per REQ-012.

Verification
REQ-015 ADD with alu_result=0x00000007 and rd=5 -> one cycle later mem_wb_valid_o=1, mem_wb_en_o=1, mem_rd_o=5, mem_wb_data_o=0x00000007, and mem_stall_o=0 throughout.
REQ-016 LB at address 0x103 with a 2-cycle wait and dm_rdata_i=0x80AABBCC -> mem_stall_o=1 for 3 cycles, then mem_wb_data_o=0xFFFFFF80 in DONE; the LBU variant returns 0x00000080.
REQ-017 SW at address 0x200, wdata=0x12345678, web=0000, ready after 0 wait cycles -> dm_req_o=1 for exactly one cycle; in DONE, mem_wb_valid_o=1 and mem_wb_en_o=0.
REQ-018 MULH of -3 by 5: EX supplies magnitudes 3 and 5 with signs 10 -> mem_wb_data_o=0xFFFFFFFF. MULHU of 0xFFFFFFFF by 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-019 While in ACC with flush_i=1 and EX inputs changing -> M is unchanged and no bubble is captured until DONE. Back-to-back LW, LW -> DONE goes directly to ACC.
REQ-020 rst asserted during ACC, then dm_ready_i pulses -> all outputs stay at reset values and mem_wb_valid_o=0.
